// File: rtl/swd_if.sv
// rtl/swd_if.sv - SWD host transaction engine (header, turnaround, ACK, read/write data phase).
// Optional trace printing is compiled in only when SWDIF_STATETRACE_EN is defined.
module swd_if #(
  parameter int STATETRACE = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        swdi,
  output logic        swdo,
  output logic        swwr,
  output logic        swclk,
  input  logic [10:0] clkDiv,
  input  logic [1:0]  addr32,
  input  logic        rnw,
  input  logic        apndp,
  input  logic [31:0] din,
  output logic [2:0]  ack,
  output logic [31:0] dout,
  output logic        err,
  input  logic        go,
  output logic        done
);

  typedef enum logic [3:0] {
    IDLE, HDR, TRN1, ACK, RDATA, RPAR, TRN2, WDATA, WPAR, DONE
  } state_t;

  state_t      state_q, state_d;
  logic [10:0] cnt_q, cnt_d;
  logic [5:0]  bit_q, bit_d;
  logic        swclk_q, swclk_d;
  logic        swdo_q, swdo_d;
  logic        swwr_q, swwr_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic [2:0]  ack_q, ack_d;
  logic [31:0] dout_q, dout_d;
  logic [1:0]  addr_q, addr_d;
  logic        rnw_q, rnw_d;
  logic        apndp_q, apndp_d;
  logic [31:0] din_q, din_d;
  logic        armed_q, armed_d;

  logic [10:0] half_cnt;
  logic [7:0]  hdr;
  logic [5:0]  last_idx;
  logic        ack_ok;
  state_t      nxt;
  logic [5:0]  nb;

  always_comb begin
    half_cnt = (clkDiv == 11'd0) ? 11'd0 : clkDiv - 11'd1;
    hdr      = {1'b1, 1'b0, ^{apndp_q, rnw_q, addr_q}, addr_q[1], addr_q[0], rnw_q, apndp_q, 1'b1};
    ack_ok   = (ack_q == 3'b100);
    case (state_q)
      HDR:          last_idx = 6'd7;
      ACK:          last_idx = 6'd2;
      RDATA, WDATA: last_idx = 6'd31;
      default:      last_idx = 6'd0;
    endcase

    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    swclk_d = swclk_q;
    swdo_d  = swdo_q;
    swwr_d  = swwr_q;
    done_d  = done_q;
    err_d   = err_q;
    ack_d   = ack_q;
    dout_d  = dout_q;
    addr_d  = addr_q;
    rnw_d   = rnw_q;
    apndp_d = apndp_q;
    din_d   = din_q;
    armed_d = armed_q;
    nxt     = state_q;
    nb      = bit_q;

    case (state_q)
      IDLE: begin
        if (!go) armed_d = 1'b1;
        if (go && armed_q) begin
          addr_d  = addr32;
          rnw_d   = rnw;
          apndp_d = apndp;
          din_d   = din;
          err_d   = 1'b0;
          done_d  = 1'b0;
          armed_d = 1'b0;
          state_d = HDR;
          bit_d   = 6'd0;
          cnt_d   = half_cnt;
          swclk_d = 1'b0;
          swwr_d  = 1'b1;
          swdo_d  = 1'b1;
        end
      end
      DONE: begin
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: begin
        if (cnt_q != 11'd0) begin
          cnt_d = cnt_q - 11'd1;
        end else if (!swclk_q) begin
          swclk_d = 1'b1;
          cnt_d   = half_cnt;
          case (state_q)
            ACK:     ack_d  = {ack_q[1:0], swdi};
            RDATA:   dout_d = {swdi, dout_q[31:1]};
            RPAR:    err_d  = (^dout_q) ^ swdi;
            default: ;
          endcase
        end else begin
          // Falling edge: pick the next bit and present its drive at the start of the low phase.
          swclk_d = 1'b0;
          cnt_d   = half_cnt;
          nb      = bit_q + 6'd1;
          if (bit_q == last_idx) begin
            nb = 6'd0;
            case (state_q)
              HDR:     nxt = TRN1;
              TRN1:    nxt = ACK;
              ACK:     nxt = (ack_ok && rnw_q) ? RDATA : TRN2;
              RDATA:   nxt = RPAR;
              RPAR:    nxt = TRN2;
              TRN2:    nxt = (ack_ok && !rnw_q) ? WDATA : DONE;
              WDATA:   nxt = WPAR;
              default: nxt = DONE;
            endcase
          end
          state_d = nxt;
          bit_d   = nb;
          case (nxt)
            HDR:     begin swwr_d = 1'b1; swdo_d = hdr[nb[2:0]];   end
            WDATA:   begin swwr_d = 1'b1; swdo_d = din_q[nb[4:0]]; end
            WPAR:    begin swwr_d = 1'b1; swdo_d = ^din_q;         end
            DONE:    begin swwr_d = 1'b1; swdo_d = 1'b0;           end
            default: begin swwr_d = 1'b0; swdo_d = 1'b0;           end
          endcase
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      swclk_q <= 1'b0;
      swdo_q  <= 1'b0;
      swwr_q  <= 1'b1;
      done_q  <= 1'b1;
      err_q   <= 1'b0;
      ack_q   <= '0;
      dout_q  <= '0;
      addr_q  <= '0;
      rnw_q   <= 1'b0;
      apndp_q <= 1'b0;
      din_q   <= '0;
      armed_q <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      swclk_q <= swclk_d;
      swdo_q  <= swdo_d;
      swwr_q  <= swwr_d;
      done_q  <= done_d;
      err_q   <= err_d;
      ack_q   <= ack_d;
      dout_q  <= dout_d;
      addr_q  <= addr_d;
      rnw_q   <= rnw_d;
      apndp_q <= apndp_d;
      din_q   <= din_d;
      armed_q <= armed_d;
    end
  end

  assign swdo  = swdo_q;
  assign swwr  = swwr_q;
  assign swclk = swclk_q;
  assign ack   = ack_q;
  assign dout  = dout_q;
  assign err   = err_q;
  assign done  = done_q;

`ifdef SWDIF_STATETRACE_EN
  if (STATETRACE != 0) begin : g_trace
    always @(posedge clk) begin
      if (rst && state_d != state_q)
        $display("swd_if: %s -> %s", state_q.name(), state_d.name());
      if (rst && swclk_d && !swclk_q)
        $display("swd_if: %s bit %0d sampled %b", state_q.name(), bit_q, swdi);
    end
  end
`else
  if (STATETRACE != 0) begin : g_no_trace
  end
`endif

endmodule

// File: tb/tb_swd_if.sv
// tb/tb_swd_if.sv - self-checking bench for swd_if with a bit-level SWD target model.
module tb_swd_if;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        swdi = 1'b0;
  logic [10:0] clkDiv = '0;
  logic [1:0]  addr32 = '0;
  logic        rnw = 1'b0;
  logic        apndp = 1'b0;
  logic [31:0] din = '0;
  logic        go = 1'b0;
  wire         swdo, swwr, swclk, err, done;
  wire  [2:0]  ack;
  wire  [31:0] dout;

  int          vec_cnt = 0;
  int          miscompares = 0;
  logic [31:0] m_dout = '0;
  int          rises, budget;
  bit          prev;

  always #5 clk = ~clk;

  swd_if #(.STATETRACE(0)) dut (
    .clk(clk), .rst(rst), .swdi(swdi), .swdo(swdo), .swwr(swwr), .swclk(swclk),
    .clkDiv(clkDiv), .addr32(addr32), .rnw(rnw), .apndp(apndp), .din(din),
    .ack(ack), .dout(dout), .err(err), .go(go), .done(done)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec_cnt++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One full transaction: build the expected wire-level bit list, act as target, check result.
  task automatic txn(input int cdiv, input logic [1:0] a, input logic r, input logic ap,
                     input logic [31:0] wd, input logic [2:0] tack, input logic [31:0] rd,
                     input logic rpar, input bit hold_go);
    bit          exp_wr[$];
    bit          exp_do[$];
    bit          drv[$];
    int          n;
    bit          ok;
    logic [7:0]  hb;
    logic        exp_err;
    int          k, cyc, last_rise;
    bit          pv, stayed;
    n  = (cdiv == 0) ? 1 : cdiv;
    ok = (tack == 3'b100);
    hb = {1'b1, 1'b0, ^{ap, r, a}, a[1], a[0], r, ap, 1'b1};
    for (int i = 0; i < 8; i++) begin exp_wr.push_back(1); exp_do.push_back(hb[i]); drv.push_back(0); end
    exp_wr.push_back(0); exp_do.push_back(0); drv.push_back(0);
    for (int i = 2; i >= 0; i--) begin exp_wr.push_back(0); exp_do.push_back(0); drv.push_back(tack[i]); end
    if (ok && r) begin
      for (int i = 0; i < 32; i++) begin exp_wr.push_back(0); exp_do.push_back(0); drv.push_back(rd[i]); end
      exp_wr.push_back(0); exp_do.push_back(0); drv.push_back(rpar);
      exp_wr.push_back(0); exp_do.push_back(0); drv.push_back(0);
      m_dout = rd;
    end else if (ok) begin
      exp_wr.push_back(0); exp_do.push_back(0); drv.push_back(0);
      for (int i = 0; i < 32; i++) begin exp_wr.push_back(1); exp_do.push_back(wd[i]); drv.push_back(0); end
      exp_wr.push_back(1); exp_do.push_back(^wd); drv.push_back(0);
    end else begin
      exp_wr.push_back(0); exp_do.push_back(0); drv.push_back(1);
    end
    exp_err = ok && r && ((^rd) ^ rpar);

    @(negedge clk);
    clkDiv = cdiv[10:0]; addr32 = a; rnw = r; apndp = ap; din = wd; swdi = drv[0]; go = 1'b1;
    @(negedge clk);
    chk("done_drop", done, 1'b0);
    if (!hold_go) go = 1'b0;
    k = 0; cyc = 0; last_rise = 0; pv = swclk;
    while (!done && cyc < 200 * n + 400) begin
      @(negedge clk);
      cyc++;
      if (swclk && !pv) begin
        if (k == 0) chk("first_rise", cyc, n);
        if (k == 2) chk("bit_period", cyc - last_rise, 2 * n);
        if (k < exp_wr.size()) begin
          if (exp_wr[k]) chk($sformatf("bit%0d_wr_do", k), {swwr, swdo}, {1'b1, exp_do[k]});
          else           chk($sformatf("bit%0d_wr", k), swwr, 1'b0);
        end
        last_rise = cyc;
        k++;
        swdi = (k < drv.size()) ? drv[k] : 1'b0;
      end
      pv = swclk;
    end
    chk("done_rise", done, 1'b1);
    chk("bit_count", k, exp_wr.size());
    chk("done_latency", cyc - last_rise, n + 1);
    chk("ack", ack, tack);
    chk("err", err, exp_err);
    chk("dout", dout, m_dout);
    chk("idle_lines", {swwr, swdo, swclk}, 3'b100);
    if (hold_go) begin
      stayed = 1;
      repeat (8) begin @(negedge clk); stayed &= done; end
      chk("go_held_ignored", stayed, 1'b1);
      go = 1'b0;
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_done", done, 1'b1);
    chk("rst_lines", {swwr, swdo, swclk}, 3'b100);
    chk("rst_ack", ack, 3'b000);
    chk("rst_dout", dout, 32'h0);
    chk("rst_err", err, 1'b0);
    rst = 1'b1;

    txn(2, 2'b01, 1, 1, 32'h0, 3'b100, 32'habcdef12, 1'b1, 0);
    txn(2, 2'b01, 1, 1, 32'h0, 3'b100, 32'habcdef12, 1'b0, 0);
    txn(2, 2'b10, 0, 0, 32'h12345678, 3'b100, 32'h0, 1'b0, 0);
    txn(2, 2'b00, 1, 0, 32'h0, 3'b010, 32'h0, 1'b0, 0);
    txn(1, 2'b11, 0, 1, 32'hdeadbeef, 3'b001, 32'h0, 1'b0, 1);
    txn(1, 2'b01, 1, 0, 32'h0, 3'b111, 32'hffffffff, 1'b1, 0);
    txn(0, 2'b10, 1, 1, 32'h0, 3'b100, 32'h00000001, 1'b1, 0);
    txn(3, 2'b11, 0, 1, 32'h80000000, 3'b100, 32'h0, 1'b0, 0);

    @(negedge clk);
    clkDiv = 11'd2; addr32 = 2'b00; rnw = 1'b1; apndp = 1'b1; swdi = 1'b0; go = 1'b1;
    @(negedge clk);
    go = 1'b0;
    rises = 0; budget = 0; prev = 0;
    while (rises < 5 && budget < 200) begin
      @(negedge clk);
      budget++;
      if (swclk && !prev) rises++;
      prev = swclk;
    end
    chk("rst_mid_reach", rises, 5);
    rst = 1'b0;
    #1;
    chk("rst_mid_done", done, 1'b1);
    chk("rst_mid_lines", {swwr, swdo, swclk}, 3'b100);
    chk("rst_mid_ack", ack, 3'b000);
    chk("rst_mid_dout", dout, 32'h0);
    m_dout = '0;
    @(negedge clk);
    rst = 1'b1;

    for (int t = 0; t < 16; t++) begin
      logic [2:0] tk;
      case ($urandom_range(0, 4))
        0, 1, 2: tk = 3'b100;
        3:       tk = 3'b010;
        default: tk = ($urandom_range(0, 1) != 0) ? 3'b001 : 3'b111;
      endcase
      txn($urandom_range(0, 4), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
          1'($urandom_range(0, 1)), $urandom, tk, $urandom, 1'($urandom_range(0, 1)), 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscompares);
    $finish;
  end
endmodule
